// File: rtl/snoop_bus_memory_if.sv
// Bus bundle between the MSI caches and the shared bus/memory responder.
// The slave modport is the bus/memory side; master is the cache side.
interface snoop_bus_memory_if #(
    parameter int unsigned N_CACHES = 3,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 7
);
    logic [N_CACHES-1:0]        req_valid;
    logic [2*N_CACHES-1:0]      req_msg;
    logic [ADDR_W*N_CACHES-1:0] req_tag;
    logic [N_CACHES-1:0]        wb_valid;
    logic [ADDR_W*N_CACHES-1:0] wb_tag;
    logic [DATA_W*N_CACHES-1:0] wb_data;
    logic [N_CACHES-1:0]        wb_ack;
    logic [N_CACHES-1:0]        req_grant;
    logic                       snoop_valid;
    logic [1:0]                 snoop_msg;
    logic [ADDR_W-1:0]          snoop_tag;
    logic [1:0]                 snoop_src;
    logic [N_CACHES-1:0]        snoop_hit;
    logic [DATA_W*N_CACHES-1:0] snoop_data;
    logic [N_CACHES-1:0]        resp_valid;
    logic [DATA_W-1:0]          resp_data;
    logic                       resp_from_cache;
    logic                       busy;

    modport slave (
        input  req_valid, req_msg, req_tag, wb_valid, wb_tag, wb_data,
               snoop_hit, snoop_data,
        output wb_ack, req_grant, snoop_valid, snoop_msg, snoop_tag, snoop_src,
               resp_valid, resp_data, resp_from_cache, busy
    );

    modport master (
        output req_valid, req_msg, req_tag, wb_valid, wb_tag, wb_data,
               snoop_hit, snoop_data,
        input  wb_ack, req_grant, snoop_valid, snoop_msg, snoop_tag, snoop_src,
               resp_valid, resp_data, resp_from_cache, busy
    );
endinterface

// File: rtl/snoop_bus_memory.sv
// Shared snooping bus plus main memory for the MSI caches: arbitrates, broadcasts, responds.
// Define SNOOP_FLUSH_UPDATE_EN to also write cache-supplied data into memory (MSI flush).
module snoop_bus_memory #(
    parameter int unsigned N_CACHES = 3,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 7,
    parameter int unsigned MEM_LAT  = 2
) (
    input  logic               clock,
    input  logic               reset,
    snoop_bus_memory_if.slave  bus
);
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, SNOOP, MEM_WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q;
    logic [1:0]        src_q;
    logic [1:0]        msg_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;
    logic              from_cache_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]        req_msg_a  [N_CACHES];
    logic [ADDR_W-1:0] req_tag_a  [N_CACHES];
    logic [ADDR_W-1:0] wb_tag_a   [N_CACHES];
    logic [DATA_W-1:0] wb_data_a  [N_CACHES];
    logic [DATA_W-1:0] snp_data_a [N_CACHES];

    logic              wb_any, req_any, hit_any;
    logic [1:0]        wb_idx, req_idx, cand;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        for (int unsigned i = 0; i < N_CACHES; i++) begin
            req_msg_a[i]  = bus.req_msg[2*i +: 2];
            req_tag_a[i]  = bus.req_tag[ADDR_W*i +: ADDR_W];
            wb_tag_a[i]   = bus.wb_tag[ADDR_W*i +: ADDR_W];
            wb_data_a[i]  = bus.wb_data[DATA_W*i +: DATA_W];
            snp_data_a[i] = bus.snoop_data[DATA_W*i +: DATA_W];
        end
    end

    // Loops run downward so the last match (lowest index / nearest the pointer) wins.
    always_comb begin
        wb_any   = 1'b0;
        wb_idx   = '0;
        req_any  = 1'b0;
        req_idx  = '0;
        cand     = '0;
        hit_any  = 1'b0;
        hit_data = '0;
        for (int unsigned i = N_CACHES; i > 0; i--) begin
            if (bus.wb_valid[i-1]) begin
                wb_any = 1'b1;
                wb_idx = 2'(i-1);
            end
        end
        for (int unsigned off = N_CACHES; off > 0; off--) begin
            cand = 2'((32'(ptr_q) + off - 1) % N_CACHES);
            if (bus.req_valid[cand] && req_msg_a[cand] != 2'b00) begin
                req_any = 1'b1;
                req_idx = cand;
            end
        end
        for (int unsigned i = N_CACHES; i > 0; i--) begin
            if (bus.snoop_hit[i-1] && 2'(i-1) != src_q) begin
                hit_any  = 1'b1;
                hit_data = snp_data_a[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!wb_any && req_any) state_d = SNOOP;
            SNOOP:    state_d = (msg_q == 2'b11 || hit_any) ? RESP : MEM_WAIT;
            MEM_WAIT: if (cnt_q == '0) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.wb_ack          = '0;
        bus.req_grant       = '0;
        bus.snoop_valid     = 1'b0;
        bus.snoop_msg       = '0;
        bus.snoop_tag       = '0;
        bus.snoop_src       = '0;
        bus.resp_valid      = '0;
        bus.resp_data       = '0;
        bus.resp_from_cache = 1'b0;
        bus.busy            = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (wb_any)       bus.wb_ack    = N_CACHES'(1) << wb_idx;
                    else if (req_any) bus.req_grant = N_CACHES'(1) << req_idx;
                end
            end
            SNOOP: begin
                bus.snoop_valid = 1'b1;
                bus.snoop_msg   = msg_q;
                bus.snoop_tag   = tag_q;
                bus.snoop_src   = src_q;
            end
            RESP: begin
                bus.resp_valid      = N_CACHES'(1) << src_q;
                bus.resp_data       = data_q;
                bus.resp_from_cache = from_cache_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q        <= '0;
            src_q        <= '0;
            msg_q        <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            from_cache_q <= 1'b0;
            cnt_q        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wb_any) begin
                        mem_q[wb_tag_a[wb_idx]] <= wb_data_a[wb_idx];
                    end else if (req_any) begin
                        src_q <= req_idx;
                        msg_q <= req_msg_a[req_idx];
                        tag_q <= req_tag_a[req_idx];
                    end
                end
                SNOOP: begin
                    if (msg_q == 2'b11) begin
                        data_q       <= '0;
                        from_cache_q <= 1'b0;
                    end else if (hit_any) begin
                        data_q       <= hit_data;
                        from_cache_q <= 1'b1;
`ifdef SNOOP_FLUSH_UPDATE_EN
                        mem_q[tag_q] <= hit_data;
`endif
                    end else begin
                        from_cache_q <= 1'b0;
                        cnt_q        <= CNT_W'(MEM_LAT - 1);
                    end
                end
                MEM_WAIT: begin
                    if (cnt_q == '0) data_q <= mem_q[tag_q];
                    else             cnt_q  <= cnt_q - 1'b1;
                end
                RESP: begin
                    ptr_q <= (32'(src_q) == N_CACHES - 1) ? '0 : src_q + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
